gomoku_turn_ctrl: RTL and testbench



---
 rtl/gomoku_turn_ctrl.sv | 178 +++++++++++++++++
 tb/tb_gomoku_turn_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gomoku_turn_ctrl.sv
// Gomoku turn controller: validates each move against the board, writes it, asks the external
// line checker for a verdict, and keeps a short circular history so moves can be withdrawn.
module gomoku_turn_ctrl #(
    parameter int unsigned BOARD_DIM  = 16,
    parameter int unsigned PLAYERS    = 2,
    parameter int unsigned UNDO_DEPTH = 4,
    localparam int unsigned CW        = $clog2(BOARD_DIM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] cur_x,
    input  logic [CW-1:0] cur_y,
    input  logic          place_req,
    input  logic          undo_req,
    output logic [CW-1:0] rd_x,
    output logic [CW-1:0] rd_y,
    input  logic [1:0]    rd_data,
    output logic          wr_en,
    output logic [CW-1:0] wr_x,
    output logic [CW-1:0] wr_y,
    output logic [1:0]    wr_data,
    output logic          chk_start,
    output logic [CW-1:0] chk_x,
    output logic [CW-1:0] chk_y,
    output logic [1:0]    chk_player,
    input  logic          chk_done,
    input  logic          chk_win,
    output logic [1:0]    cur_player,
    output logic [1:0]    winner,
    output logic          game_over,
    output logic          busy,
    output logic          reject,
    output logic [3:0]    undo_avail
);

    localparam int unsigned MCW = $clog2(BOARD_DIM * BOARD_DIM + 1);
    localparam int unsigned HPW = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
    localparam int unsigned CW1 = CW + 1;

    localparam logic [MCW-1:0] NumCells   = MCW'(BOARD_DIM * BOARD_DIM);
    localparam logic [CW:0]    DimLimit   = CW1'(BOARD_DIM);
    localparam logic [HPW-1:0] LastSlot   = HPW'(UNDO_DEPTH - 1);
    localparam logic [3:0]     DepthCnt   = 4'(UNDO_DEPTH);
    localparam logic [1:0]     LastPlayer = 2'(PLAYERS);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StVerify   = 3'd1;
    localparam logic [2:0] StWrite    = 3'd2;
    localparam logic [2:0] StChkStart = 3'd3;
    localparam logic [2:0] StChkWait  = 3'd4;
    localparam logic [2:0] StUndo     = 3'd5;
    localparam logic [2:0] StWin      = 3'd6;
    localparam logic [2:0] StDraw     = 3'd7;

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  move_x_q, move_y_q;
    logic [1:0]     player_q;
    logic [MCW-1:0] move_count_q;
    logic [HPW-1:0] head_q;
    logic [3:0]     avail_q;
    logic [CW-1:0]  hist_x_q [UNDO_DEPTH];
    logic [CW-1:0]  hist_y_q [UNDO_DEPTH];

    logic [HPW-1:0] prev_slot, next_slot;
    logic [1:0]     next_player, prev_player;
    logic           move_bad;

    // head_q points at the next free slot; the most recent move sits one slot behind it.
    assign prev_slot   = (head_q == '0) ? LastSlot : head_q - HPW'(1);
    assign next_slot   = (head_q == LastSlot) ? '0 : head_q + HPW'(1);
    assign next_player = (player_q == LastPlayer) ? 2'd1 : player_q + 2'd1;
    assign prev_player = (player_q == 2'd1) ? LastPlayer : player_q - 2'd1;
    assign move_bad    = (rd_data != 2'd0) || ({1'b0, move_x_q} >= DimLimit)
                      || ({1'b0, move_y_q} >= DimLimit);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (undo_req) begin
                    if (avail_q != 4'd0) state_d = StUndo;
                end else if (place_req) begin
                    state_d = StVerify;
                end
            end
            StVerify:   state_d = move_bad ? StIdle : StWrite;
            StWrite:    state_d = StChkStart;
            StChkStart: state_d = StChkWait;
            StChkWait: begin
                if (chk_done) begin
                    if (chk_win)                        state_d = StWin;
                    else if (move_count_q == NumCells)  state_d = StDraw;
                    else                                state_d = StIdle;
                end
            end
            StUndo:  state_d = StIdle;
            StWin:   state_d = StWin;
            StDraw:  state_d = StDraw;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_x    = move_x_q;
        wr_y    = move_y_q;
        wr_data = player_q;
        reject  = 1'b0;
        case (state_q)
            StIdle:   reject = undo_req && (avail_q == 4'd0);
            StVerify: reject = move_bad;
            StWrite:  wr_en  = 1'b1;
            StUndo: begin
                wr_en   = 1'b1;
                wr_x    = hist_x_q[prev_slot];
                wr_y    = hist_y_q[prev_slot];
                wr_data = 2'd0;
            end
            default: ;
        endcase
    end

    assign rd_x       = move_x_q;
    assign rd_y       = move_y_q;
    assign chk_start  = (state_q == StChkStart);
    assign chk_x      = move_x_q;
    assign chk_y      = move_y_q;
    assign chk_player = player_q;
    assign cur_player = player_q;
    assign winner     = (state_q == StWin) ? player_q : 2'd0;
    assign game_over  = (state_q == StWin) || (state_q == StDraw);
    assign busy       = (state_q != StIdle);
    assign undo_avail = avail_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            move_x_q     <= '0;
            move_y_q     <= '0;
            player_q     <= 2'd1;
            move_count_q <= '0;
            head_q       <= '0;
            avail_q      <= 4'd0;
            hist_x_q     <= '{default: '0};
            hist_y_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (place_req && !undo_req) begin
                        move_x_q <= cur_x;
                        move_y_q <= cur_y;
                    end
                end
                StWrite: begin
                    hist_x_q[head_q] <= move_x_q;
                    hist_y_q[head_q] <= move_y_q;
                    head_q           <= next_slot;
                    if (avail_q != DepthCnt) avail_q <= avail_q + 4'd1;
                    move_count_q     <= move_count_q + MCW'(1);
                end
                StChkWait: begin
                    if (chk_done && !chk_win && (move_count_q != NumCells)) begin
                        player_q <= next_player;
                    end
                end
                StUndo: begin
                    head_q       <= prev_slot;
                    avail_q      <= avail_q - 4'd1;
                    move_count_q <= move_count_q - MCW'(1);
                    player_q     <= prev_player;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gomoku_turn_ctrl.sv
// Scoreboard bench for gomoku_turn_ctrl on a 5x5 board with two players and a 4-deep undo history.
module tb_gomoku_turn_ctrl;

    localparam int Dim     = 5;
    localparam int Players = 2;
    localparam int Depth   = 4;
    localparam int Cells   = Dim * Dim;
    localparam int KWr     = 0;
    localparam int KChk    = 1;
    localparam int KRej    = 2;

    typedef struct {
        int kind;
        int x;
        int y;
        int d;
        int cyc;
    } evt_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] cur_x = 3'd0;
    logic [2:0] cur_y = 3'd0;
    logic       place_req = 1'b0;
    logic       undo_req = 1'b0;
    logic [2:0] rd_x, rd_y;
    logic [1:0] rd_data;
    logic       wr_en;
    logic [2:0] wr_x, wr_y;
    logic [1:0] wr_data;
    logic       chk_start;
    logic [2:0] chk_x, chk_y;
    logic [1:0] chk_player;
    logic       chk_done = 1'b0;
    logic       chk_win = 1'b0;
    logic [1:0] cur_player, winner;
    logic       game_over, busy, reject;
    logic [3:0] undo_avail;

    gomoku_turn_ctrl #(
        .BOARD_DIM (Dim),
        .PLAYERS   (Players),
        .UNDO_DEPTH(Depth)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .place_req (place_req),
        .undo_req  (undo_req),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .chk_start (chk_start),
        .chk_x     (chk_x),
        .chk_y     (chk_y),
        .chk_player(chk_player),
        .chk_done  (chk_done),
        .chk_win   (chk_win),
        .cur_player(cur_player),
        .winner    (winner),
        .game_over (game_over),
        .busy      (busy),
        .reject    (reject),
        .undo_avail(undo_avail)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External board memory: written by the DUT, cleared by its own reset.
    logic [1:0] mem [Cells];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Cells; i++) mem[i] <= 2'd0;
        end else if (wr_en && (wr_x < 3'd5) && (wr_y < 3'd5)) begin
            mem[int'(wr_x) * Dim + int'(wr_y)] <= wr_data;
        end
    end
    always_comb begin
        rd_data = 2'd0;
        if ((rd_x < 3'd5) && (rd_y < 3'd5)) rd_data = mem[int'(rd_x) * Dim + int'(rd_y)];
    end

    int   errors = 0;
    int   checks = 0;
    evt_t exp_q[$];

    // Reference game model.
    int m_board [Cells];
    int m_player, m_count, m_over, m_winner;
    int m_hist[$];

    function automatic void push_evt(int k, int x, int y, int d, int c);
        evt_t e;
        e.kind = k; e.x = x; e.y = y; e.d = d; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < Cells; i++) m_board[i] = 0;
        m_player = 1; m_count = 0; m_over = 0; m_winner = 0;
        m_hist.delete();
    endfunction

    task automatic model_place(input int x, input int y, input int t, output bit go);
        bit bad;
        go = 1'b0;
        if (m_over != 0) return;
        bad = (x >= Dim) || (y >= Dim);
        if (!bad) bad = (m_board[x * Dim + y] != 0);
        if (bad) begin
            push_evt(KRej, 0, 0, 0, t + 1);
        end else begin
            push_evt(KWr, x, y, m_player, t + 2);
            push_evt(KChk, x, y, m_player, t + 3);
            m_board[x * Dim + y] = m_player;
            m_count++;
            m_hist.push_back(x * Dim + y);
            if (m_hist.size() > Depth) void'(m_hist.pop_front());
            go = 1'b1;
        end
    endtask

    function automatic void model_result(bit win);
        if (win) begin
            m_over = 1; m_winner = m_player;
        end else if (m_count == Cells) begin
            m_over = 1; m_winner = 0;
        end else begin
            m_player = (m_player % Players) + 1;
        end
    endfunction

    function automatic void model_undo(int t);
        int c;
        if (m_over != 0) return;
        if (m_hist.size() == 0) begin
            push_evt(KRej, 0, 0, 0, t);
        end else begin
            c = m_hist.pop_back();
            push_evt(KWr, c / Dim, c % Dim, 0, t + 1);
            m_board[c] = 0;
            m_count--;
            m_player = (m_player == 1) ? Players : m_player - 1;
        end
    endfunction

    task automatic chk1(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_evt(input int k, input int x, input int y, input int d);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind=%0d x=%0d y=%0d data=%0d cycle=%0d, expected none",
                     k, x, y, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || (k != KRej && (e.x != x || e.y != y || e.d != d)))
            begin
                errors++;
                $display("FAIL event: got kind=%0d x=%0d y=%0d data=%0d cycle=%0d, expected kind=%0d x=%0d y=%0d data=%0d cycle=%0d",
                         k, x, y, d, cyc, e.kind, e.x, e.y, e.d, e.cyc);
            end
        end
    endtask

    // Monitor: every pulse output the DUT presents must match the next expected event.
    always @(negedge clk) begin
        if (wr_en)     check_evt(KWr, int'(wr_x), int'(wr_y), int'(wr_data));
        if (chk_start) check_evt(KChk, int'(chk_x), int'(chk_y), int'(chk_player));
        if (reject)    check_evt(KRej, 0, 0, 0);
    end

    task automatic check_state(input string tag);
        chk1({tag, " cur_player"}, int'(cur_player), m_player);
        chk1({tag, " undo_avail"}, int'(undo_avail), m_hist.size());
        chk1({tag, " game_over"}, int'(game_over), m_over);
        chk1({tag, " winner"}, int'(winner), m_winner);
        chk1({tag, " busy"}, int'(busy), m_over);
    endtask

    task automatic do_reset();
        chk1("queue_drained_before_reset", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1; place_req = 1'b0; undo_req = 1'b0; chk_done = 1'b0; chk_win = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_place(input int x, input int y, input bit win, input bit poke,
                            input bit abort);
        bit go;
        bit got;
        int t;
        @(posedge clk); #1;
        cur_x = 3'(x); cur_y = 3'(y); place_req = 1'b1; t = cyc;
        model_place(x, y, t, go);
        @(posedge clk); #1;
        place_req = 1'b0;
        if (!go) begin
            repeat (2) @(posedge clk);
            #1;
            return;
        end
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (chk_start) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL chk_start_timeout: got no chk_start, expected one at cycle %0d", t + 3);
        end
        @(posedge clk); #1;
        if (abort) return;
        if (poke) begin
            cur_x = 3'($urandom_range(0, 4)); place_req = 1'b1; undo_req = 1'b1;
            @(posedge clk); #1;
            place_req = 1'b0; undo_req = 1'b0;
        end
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
        chk_done = 1'b1; chk_win = win;
        model_result(win);
        @(posedge clk); #1;
        chk_done = 1'b0; chk_win = 1'b0;
    endtask

    task automatic do_undo(input bit with_place);
        int t;
        @(posedge clk); #1;
        undo_req = 1'b1; place_req = with_place; cur_x = 3'd4; cur_y = 3'd0; t = cyc;
        model_undo(t);
        @(posedge clk); #1;
        undo_req = 1'b0; place_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic stray_done();
        @(posedge clk); #1;
        chk_done = 1'b1; chk_win = 1'b1;
        @(posedge clk); #1;
        chk_done = 1'b0; chk_win = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_state("reset");
        chk1("reset wr_en", int'(wr_en), 0);
        chk1("reset chk_start", int'(chk_start), 0);
        chk1("reset reject", int'(reject), 0);

        do_place(3, 4, 1'b0, 1'b0, 1'b0);
        check_state("first_move");
        do_place(0, 0, 1'b0, 1'b1, 1'b0);
        do_place(0, 0, 1'b0, 1'b0, 1'b0);
        check_state("occupied");
        do_place(6, 1, 1'b0, 1'b0, 1'b0);
        do_place(2, 7, 1'b0, 1'b0, 1'b0);
        check_state("out_of_range");
        stray_done();
        check_state("stray_done");
        do_undo(1'b1);
        check_state("undo_priority");

        do_reset();
        for (int i = 0; i < 6; i++) do_place(i / Dim, i % Dim, 1'b0, 1'(i % 2), 1'b0);
        check_state("six_moves");
        repeat (5) do_undo(1'b0);
        check_state("five_undos");

        do_reset();
        do_place(2, 2, 1'b0, 1'b0, 1'b0);
        do_place(1, 1, 1'b1, 1'b0, 1'b0);
        check_state("win");
        do_place(3, 3, 1'b0, 1'b0, 1'b0);
        do_undo(1'b0);
        check_state("win_absorbing");

        do_reset();
        do_place(4, 4, 1'b0, 1'b0, 1'b1);
        do_reset();
        stray_done();
        check_state("reset_in_chk_wait");

        do_reset();
        for (int n = 0; n < 200; n++) begin
            if (m_over != 0) do_reset();
            r = $urandom_range(0, 9);
            if (r < 2)       do_undo(1'(r));
            else if (r == 2) stray_done();
            else do_place($urandom_range(0, 6), $urandom_range(0, 6),
                          ($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)), 1'b0);
            check_state("random");
        end

        do_reset();
        for (int i = 0; i < Cells; i++) do_place(i / Dim, i % Dim, 1'b0, 1'b0, 1'b0);
        check_state("draw");
        chk1("draw game_over", int'(game_over), 1);
        do_place(0, 0, 1'b0, 1'b0, 1'b0);
        do_undo(1'b0);
        check_state("draw_absorbing");

        chk1("queue_drained_at_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
